// File: rtl/memofs_wrap_stage.sv
// Memory-offset stage: per-config N-D wrapping offset counters, shuffled and accumulated onto
// per-config start offsets, delivered through a small registered output FIFO.
module memofs_wrap_stage #(
   parameter  int N_CFG    = 4,
   parameter  int DIM      = 4,
   parameter  int GBW      = 32,
   parameter  int SHAMT_BW = 3,
   parameter  int DEPTH    = 2,
   localparam int CFG_BW   = $clog2(N_CFG + 1),
   localparam int DIM_BW   = $clog2(DIM),
   localparam int CNT_BW   = $clog2(DEPTH + 1)
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic                                  src_rdy,
   output logic                                  src_ack,
   input  logic [CFG_BW-1:0]                     i_id,
   input  logic [DIM-1:0]                        i_reset_flag,
   input  logic [DIM-1:0]                        i_add_flag,
   input  logic [DIM-1:0][SHAMT_BW-1:0]          i_shamt,
   input  logic [N_CFG-1:0][DIM-1:0][GBW-1:0]    i_steps,
   input  logic [N_CFG-1:0][DIM-1:0][GBW-1:0]    i_bounds,
   input  logic [N_CFG-1:0][DIM-1:0][GBW-1:0]    i_starts,
   input  logic [N_CFG-1:0][DIM-1:0][DIM_BW-1:0] i_shufs,
   input  logic                                  i_sum_all,
   input  logic                                  i_islast,
   input  logic                                  i_clear,
   output logic                                  dst_rdy,
   input  logic                                  dst_ack,
   output logic [DIM-1:0][GBW-1:0]               o_mofs,
   output logic [CFG_BW-1:0]                     o_id,
   output logic                                  islast_dval
);

   typedef struct packed {
      logic [DIM-1:0][GBW-1:0] mofs;
      logic [CFG_BW-1:0]       id;
      logic                    islast;
   } entry_t;

   logic [DIM-1:0][GBW-1:0]    cnt_q [N_CFG];
   logic [DIM-1:0][GBW-1:0]    cnt_d [N_CFG];
   logic [DIM-1:0][GBW-1:0]    raw, sel_steps, sel_bounds, sel_starts;
   logic [DIM-1:0][DIM_BW-1:0] sel_shufs;
   logic [DIM-1:0][GBW-1:0]    base, step_s, sum_t, nxt, lane;

   entry_t              mem_q [DEPTH];
   entry_t              mem_d [DEPTH];
   entry_t              new_entry;
   logic [CNT_BW-1:0]   count_q, count_d, wr_pos;
   logic                push, pop;

   assign src_ack     = src_rdy & ~i_rst & (count_q < CNT_BW'(DEPTH));
   assign dst_rdy     = (count_q != '0);
   assign push        = src_ack;
   assign pop         = dst_ack & dst_rdy;
   assign o_mofs      = mem_q[0].mofs;
   assign o_id        = mem_q[0].id;
   assign islast_dval = pop & mem_q[0].islast;

   // Bank select, counter step/wrap and lane reduction for the offered beat.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      raw        = '0;
      sel_steps  = '0;
      sel_bounds = '0;
      sel_starts = '0;
      sel_shufs  = '0;
      for (int b = 0; b < N_CFG; b++) begin
         if (i_id == CFG_BW'(b)) begin
            raw        = cnt_q[b];
            sel_steps  = i_steps[b];
            sel_bounds = i_bounds[b];
            sel_starts = i_starts[b];
            sel_shufs  = i_shufs[b];
         end
      end
      for (int d = 0; d < DIM; d++) begin
         base[d]   = i_reset_flag[d] ? '0 : raw[d];
         step_s[d] = i_add_flag[d] ? (sel_steps[d] << i_shamt[d]) : '0;
         sum_t[d]  = base[d] + step_s[d];
         nxt[d]    = ((sel_bounds[d] != '0) && (sum_t[d] >= sel_bounds[d]))
                     ? sum_t[d] - sel_bounds[d] : sum_t[d];
      end
      for (int j = 0; j < DIM; j++)
         lane[j] = i_sum_all ? ((j == 0) ? sel_starts[0] : '0) : sel_starts[j];
      for (int i = 0; i < DIM; i++) begin
         if (i_sum_all)
            lane[0] = lane[0] + nxt[i];
         else
            for (int j = 0; j < DIM; j++)
               if (sel_shufs[i] == DIM_BW'(j))
                  lane[j] = lane[j] + nxt[i];
      end
      for (int b = 0; b < N_CFG; b++) begin
         cnt_d[b] = cnt_q[b];
         if (i_clear)
            cnt_d[b] = '0;
         else if (push && (i_id == CFG_BW'(b)))
            cnt_d[b] = nxt;
      end
   end

   // Shift FIFO with entry 0 as head; a pop that empties it leaves entry 0 untouched so the
   // outputs hold the last popped value.
   always_comb begin
      new_entry = '{mofs: lane, id: i_id, islast: i_islast};
      mem_d     = mem_q;
      wr_pos    = count_q - CNT_BW'(pop);
      count_d   = count_q + CNT_BW'(push) - CNT_BW'(pop);
      for (int k = 0; k < DEPTH - 1; k++)
         if (pop && ((k + 1) < int'(count_q)))
            mem_d[k] = mem_q[k + 1];
      for (int k = 0; k < DEPTH; k++)
         if (push && (wr_pos == CNT_BW'(k)))
            mem_d[k] = new_entry;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
         // NOTE: the FIFO storage is reset too, because the head drives the outputs and
         // must read as zero out of reset.
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
         for (int b = 0; b < N_CFG; b++) cnt_q[b] <= '0;
      end else begin
         count_q <= count_d;
         mem_q   <= mem_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_memofs_wrap_stage.sv
// Directed bench for memofs_wrap_stage: counters, wrap, shift, banking, reduction modes,
// FIFO back-pressure, clear and asynchronous reset.
module tb_memofs_wrap_stage;

   logic                    i_clk = 1'b0;
   logic                    i_rst;
   logic                    src_rdy;
   logic                    src_ack;
   logic [2:0]              i_id;
   logic [3:0]              i_reset_flag;
   logic [3:0]              i_add_flag;
   logic [3:0][2:0]         i_shamt;
   logic [3:0][3:0][31:0]   i_steps;
   logic [3:0][3:0][31:0]   i_bounds;
   logic [3:0][3:0][31:0]   i_starts;
   logic [3:0][3:0][1:0]    i_shufs;
   logic                    i_sum_all;
   logic                    i_islast;
   logic                    i_clear;
   logic                    dst_rdy;
   logic                    dst_ack;
   logic [3:0][31:0]        o_mofs;
   logic [2:0]              o_id;
   logic                    islast_dval;

   int n_cmp = 0;
   int n_bad = 0;

   memofs_wrap_stage dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .src_rdy     (src_rdy),
      .src_ack     (src_ack),
      .i_id        (i_id),
      .i_reset_flag(i_reset_flag),
      .i_add_flag  (i_add_flag),
      .i_shamt     (i_shamt),
      .i_steps     (i_steps),
      .i_bounds    (i_bounds),
      .i_starts    (i_starts),
      .i_shufs     (i_shufs),
      .i_sum_all   (i_sum_all),
      .i_islast    (i_islast),
      .i_clear     (i_clear),
      .dst_rdy     (dst_rdy),
      .dst_ack     (dst_ack),
      .o_mofs      (o_mofs),
      .o_id        (o_id),
      .islast_dval (islast_dval)
   );

   always #5 i_clk = ~i_clk;

   // Offer one beat for one cycle; acc reports whether it was taken.
   task automatic beat(input logic [2:0] id, input logic [3:0] rf, input logic [3:0] af,
                       input logic sa, input logic il, input logic clr, output logic acc);
      @(negedge i_clk);
      src_rdy = 1'b1; i_id = id; i_reset_flag = rf; i_add_flag = af;
      i_sum_all = sa; i_islast = il; i_clear = clr;
      #1 acc = src_ack;
      @(posedge i_clk);
      #1;
      src_rdy = 1'b0; i_reset_flag = '0; i_add_flag = '0;
      i_sum_all = 1'b0; i_islast = 1'b0; i_clear = 1'b0;
   endtask

   task automatic pop(output logic il);
      @(negedge i_clk);
      dst_ack = 1'b1;
      #1 il = islast_dval;
      @(posedge i_clk);
      #1 dst_ack = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; src_rdy = 1'b1;
      repeat (2) @(negedge i_clk);
      #1;
      n_cmp++;
      if (dst_rdy !== 1'b0 || src_ack !== 1'b0 || islast_dval !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got rdy=%b ack=%b last=%b, expected 0/0/0",
                  dst_rdy, src_ack, islast_dval);
      end
      n_cmp++;
      if (o_mofs !== '0 || o_id !== 3'd0) begin
         n_bad++;
         $display("FAIL reset_data: got mofs=%h id=%0d, expected 0/0", o_mofs, o_id);
      end
      src_rdy = 1'b0; i_rst = 1'b0;
   endtask

   task automatic test_basic();
      logic acc, il;
      for (int k = 1; k <= 3; k++) begin
         beat(3'd0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, acc);
         n_cmp++;
         if (acc !== 1'b1 || dst_rdy !== 1'b1 || o_mofs[0] !== 32'(100 + k)) begin
            n_bad++;
            $display("FAIL basic_lane0 beat %0d: got ack=%b rdy=%b lane0=%0d, expected 1/1/%0d",
                     k, acc, dst_rdy, o_mofs[0], 100 + k);
         end
         n_cmp++;
         if (o_mofs[1] !== 32'd200 || o_mofs[2] !== 32'd300 || o_mofs[3] !== 32'd400 ||
             o_id !== 3'd0) begin
            n_bad++;
            $display("FAIL basic_lanes beat %0d: got %0d %0d %0d id=%0d, expected 200 300 400 id=0",
                     k, o_mofs[1], o_mofs[2], o_mofs[3], o_id);
         end
         pop(il);
      end
   endtask

   task automatic test_wrap_shift();
      logic acc, il;
      int exp_w [5] = '{101, 102, 100, 101, 102};
      int exp_s [3] = '{104, 108, 112};
      i_bounds[0][0] = 32'd3;
      for (int k = 0; k < 5; k++) begin
         beat(3'd0, (k == 0) ? 4'b0001 : 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, acc);
         n_cmp++;
         if (o_mofs[0] !== 32'(exp_w[k])) begin
            n_bad++;
            $display("FAIL wrap beat %0d: got lane0=%0d, expected %0d", k, o_mofs[0], exp_w[k]);
         end
         pop(il);
      end
      i_bounds[0][0] = 32'd0;
      i_shamt[0]     = 3'd2;
      for (int k = 0; k < 3; k++) begin
         beat(3'd0, (k == 0) ? 4'b0001 : 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, acc);
         n_cmp++;
         if (o_mofs[0] !== 32'(exp_s[k]) || o_mofs[1] !== 32'd200) begin
            n_bad++;
            $display("FAIL shift beat %0d: got lane0=%0d lane1=%0d, expected %0d/200",
                     k, o_mofs[0], o_mofs[1], exp_s[k]);
         end
         pop(il);
      end
      i_shamt[0] = 3'd0;
   endtask

   task automatic test_banks();
      logic acc, il;
      logic [2:0] ids [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
      int exp_l1 [4] = '{202, 2020, 204, 2040};
      int exp_l0 [4] = '{100, 1000, 100, 1000};
      @(negedge i_clk);
      i_clear = 1'b1;
      @(posedge i_clk);
      #1 i_clear = 1'b0;
      for (int k = 0; k < 4; k++) begin
         beat(ids[k], 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, acc);
         n_cmp++;
         if (o_id !== ids[k] || o_mofs[1] !== 32'(exp_l1[k]) || o_mofs[0] !== 32'(exp_l0[k])) begin
            n_bad++;
            $display("FAIL banks beat %0d: got id=%0d lane0=%0d lane1=%0d, expected %0d/%0d/%0d",
                     k, o_id, o_mofs[0], o_mofs[1], ids[k], exp_l0[k], exp_l1[k]);
         end
         pop(il);
      end
   endtask

   task automatic test_reduce();
      logic acc, il;
      beat(3'd2, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, acc);
      n_cmp++;
      if (o_mofs[0] !== 32'd110 || o_mofs[1] !== '0 || o_mofs[2] !== '0 || o_mofs[3] !== '0) begin
         n_bad++;
         $display("FAIL sum_all: got %0d %0d %0d %0d, expected 110 0 0 0",
                  o_mofs[0], o_mofs[1], o_mofs[2], o_mofs[3]);
      end
      pop(il);
      beat(3'd2, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, acc);
      n_cmp++;
      if (o_mofs[0] !== 32'd103 || o_mofs[1] !== 32'd107 || o_mofs[2] !== 32'd500 ||
          o_mofs[3] !== 32'd600) begin
         n_bad++;
         $display("FAIL shuffle: got %0d %0d %0d %0d, expected 103 107 500 600",
                  o_mofs[0], o_mofs[1], o_mofs[2], o_mofs[3]);
      end
      pop(il);
   endtask

   task automatic test_backpressure();
      logic acc1, acc2, acc3, il1, il2;
      beat(3'd3, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, acc1);
      beat(3'd3, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, acc2);
      beat(3'd3, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, acc3);
      n_cmp++;
      if (acc1 !== 1'b1 || acc2 !== 1'b1 || acc3 !== 1'b0) begin
         n_bad++;
         $display("FAIL full_ack: got %b%b%b, expected 110", acc1, acc2, acc3);
      end
      n_cmp++;
      if (dst_rdy !== 1'b1 || o_mofs[0] !== 32'd5 || o_id !== 3'd3) begin
         n_bad++;
         $display("FAIL full_head: got rdy=%b lane0=%0d id=%0d, expected 1/5/3",
                  dst_rdy, o_mofs[0], o_id);
      end
      pop(il1);
      n_cmp++;
      if (il1 !== 1'b0 || dst_rdy !== 1'b1 || o_mofs[0] !== 32'd10) begin
         n_bad++;
         $display("FAIL pop1: got last=%b rdy=%b lane0=%0d, expected 0/1/10",
                  il1, dst_rdy, o_mofs[0]);
      end
      pop(il2);
      n_cmp++;
      if (il2 !== 1'b1 || dst_rdy !== 1'b0 || o_mofs[0] !== 32'd10) begin
         n_bad++;
         $display("FAIL pop2_hold: got last=%b rdy=%b lane0=%0d, expected 1/0/10",
                  il2, dst_rdy, o_mofs[0]);
      end
      beat(3'd3, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, acc1);
      n_cmp++;
      if (o_mofs[0] !== 32'd15) begin
         n_bad++;
         $display("FAIL refused_no_update: got lane0=%0d, expected 15", o_mofs[0]);
      end
      // Push and pop together with one entry held.
      @(negedge i_clk);
      src_rdy = 1'b1; i_id = 3'd3; i_add_flag = 4'b0001; dst_ack = 1'b1;
      #1;
      n_cmp++;
      if (src_ack !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_ack: got %b, expected 1", src_ack);
      end
      @(posedge i_clk);
      #1;
      src_rdy = 1'b0; i_add_flag = '0; dst_ack = 1'b0;
      n_cmp++;
      if (dst_rdy !== 1'b1 || o_mofs[0] !== 32'd20) begin
         n_bad++;
         $display("FAIL b2b_head: got rdy=%b lane0=%0d, expected 1/20", dst_rdy, o_mofs[0]);
      end
      pop(il1);
      n_cmp++;
      if (dst_rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_drain: got rdy=%b, expected 0", dst_rdy);
      end
   endtask

   task automatic test_clear_reset();
      logic acc, il;
      beat(3'd0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, acc);
      n_cmp++;
      if (acc !== 1'b1 || o_mofs[0] !== 32'd101 || o_mofs[1] !== 32'd204) begin
         n_bad++;
         $display("FAIL clear_push: got ack=%b lane0=%0d lane1=%0d, expected 1/101/204",
                  acc, o_mofs[0], o_mofs[1]);
      end
      pop(il);
      beat(3'd0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, acc);
      n_cmp++;
      if (o_mofs[0] !== 32'd101 || o_mofs[1] !== 32'd200) begin
         n_bad++;
         $display("FAIL after_clear: got lane0=%0d lane1=%0d, expected 101/200",
                  o_mofs[0], o_mofs[1]);
      end
      pop(il);
      beat(3'd0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, acc);
      @(negedge i_clk);
      i_rst = 1'b1; src_rdy = 1'b1;
      #1;
      n_cmp++;
      if (dst_rdy !== 1'b0 || src_ack !== 1'b0 || o_mofs !== '0 || o_id !== 3'd0) begin
         n_bad++;
         $display("FAIL async_reset: got rdy=%b ack=%b mofs=%h id=%0d, expected 0/0/0/0",
                  dst_rdy, src_ack, o_mofs, o_id);
      end
      @(negedge i_clk);
      src_rdy = 1'b0; i_rst = 1'b0;
      beat(3'd0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, acc);
      n_cmp++;
      if (dst_rdy !== 1'b1 || o_mofs[0] !== 32'd101 || o_mofs[1] !== 32'd200) begin
         n_bad++;
         $display("FAIL post_reset: got rdy=%b lane0=%0d lane1=%0d, expected 1/101/200",
                  dst_rdy, o_mofs[0], o_mofs[1]);
      end
      pop(il);
   endtask

   initial begin
      i_rst = 1'b1; src_rdy = 1'b0; dst_ack = 1'b0; i_id = '0;
      i_reset_flag = '0; i_add_flag = '0; i_shamt = '0;
      i_sum_all = 1'b0; i_islast = 1'b0; i_clear = 1'b0;
      i_steps = '0; i_bounds = '0; i_starts = '0; i_shufs = '0;
      for (int d = 0; d < 4; d++) begin
         i_steps[0][d]  = 32'(d + 1);
         i_starts[0][d] = 32'(100 * (d + 1));
         i_shufs[0][d]  = 2'(d);
         i_steps[1][d]  = 32'(10 * (d + 1));
         i_starts[1][d] = 32'(1000 * (d + 1));
         i_shufs[1][d]  = 2'(d);
         i_steps[2][d]  = 32'(d + 1);
         i_shufs[2][d]  = 2'(d / 2);
         i_shufs[3][d]  = 2'(d);
      end
      i_starts[2][0] = 32'd100;
      i_starts[2][1] = 32'd100;
      i_starts[2][2] = 32'd500;
      i_starts[2][3] = 32'd600;
      i_steps[3][0]  = 32'd5;

      test_reset();
      test_basic();
      test_wrap_shift();
      test_banks();
      test_reduce();
      test_backpressure();
      test_clear_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
